// File: rtl/tx_sender.sv
// Serial frame transmitter: free-running link clock plus flag/header/payload/CRC-8
// framing on tx_line, with a start/busy/done request handshake.
module tx_sender #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned GAP_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   dest_id,
    input  logic [1:0]   src_id,
    input  logic [127:0] payload,
    output logic         tx_clk,
    output logic         tx_line,
    output logic         busy,
    output logic         done,
    output logic [7:0]   frame_cnt
);

    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FLAG_BITS = 8;
    localparam int unsigned DATA_BITS = 132;
    localparam int unsigned CRC_BITS  = 8;
    localparam int unsigned SHIFT_W   = FLAG_BITS + DATA_BITS;
    localparam int unsigned CNT_MAX   = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [7:0] FLAG_BYTE = 8'h7E;
    localparam logic [7:0] CRC_POLY  = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_DATA,
        S_CRC,
        S_GAP
    } state_e;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tx_clk_q, tx_clk_d;
    logic               bit_tick_c;

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [7:0]         crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               line_q, line_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    // One serial CRC-8 step, MSB-first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC_POLY : 8'h00);
    endfunction

    // Link clock divider; a bit boundary is the falling edge of tx_clk.
    always_comb begin
        div_d      = div_q + DIV_W'(1);
        tx_clk_d   = tx_clk_q;
        bit_tick_c = 1'b0;
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d      = '0;
            tx_clk_d   = ~tx_clk_q;
            bit_tick_c = tx_clk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            tx_clk_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            tx_clk_q <= tx_clk_d;
        end
    end

    // Framing FSM: next state and datapath updates.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                busy_d = 1'b0;
                // The done cycle still reads IDLE; a start there is dropped.
                if (start && !done_q) begin
                    shift_d = {FLAG_BYTE, dest_id, src_id, payload};
                    crc_d   = 8'h00;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FLAG;
                end
            end

            S_FLAG: begin
                if (bit_tick_c) begin
                    line_d  = shift_q[SHIFT_W-1];
                    shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
                    if (cnt_q == CNT_W'(FLAG_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (bit_tick_c) begin
                    line_d  = shift_q[SHIFT_W-1];
                    shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
                    crc_d   = crc8_step(crc_q, shift_q[SHIFT_W-1]);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_CRC: begin
                // The CRC register doubles as the output shifter.
                if (bit_tick_c) begin
                    line_d = crc_q[7];
                    crc_d  = {crc_q[6:0], 1'b0};
                    if (cnt_q == CNT_W'(CRC_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_GAP: begin
                if (bit_tick_c) begin
                    line_d = 1'b1;
                    if (cnt_q == CNT_W'(GAP_BITS)) begin
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            crc_q       <= 8'h00;
            cnt_q       <= '0;
            line_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_clk    = tx_clk_q;
    assign tx_line   = line_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule
